fpu_div_ctrl: RTL

Sequencing controller for the FPU significand divider and its post-normaliser (fpu_div). It accepts one single-precision divide at a time from the FPU issue stage over a valid/ready handshake. It unpacks the operands and drives the divider's operand, exponent and start signals. It then waits for completion, buffers the normalised result for the rounding stage, and handles special operands, pipeline flush and a hung divider.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_div_classify.sv | 45 ++++
 rtl/fpu_div_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision divide path: controller states,
// special-result codes, IEEE-754 single field positions and operand unpack helpers.
`timescale 1ns/1ps
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } div_state_t;

    localparam logic [2:0] SPC_NONE  = 3'd0;
    localparam logic [2:0] SPC_QNAN  = 3'd1;
    localparam logic [2:0] SPC_DZINF = 3'd2;
    localparam logic [2:0] SPC_INF   = 3'd3;
    localparam logic [2:0] SPC_ZERO  = 3'd4;

    localparam int unsigned EXP_BIAS = 127;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_MSB  = 22;

    // Denormals use exponent 1 so the divider sees a consistent scale.
    function automatic logic [7:0] fp_eff_exp(input logic [7:0] e);
        return (e == '0) ? 8'd1 : e;
    endfunction

    function automatic logic [23:0] fp_sig(input logic [30:0] mag);
        return {|mag[EXP_MSB:EXP_LSB], mag[MAN_MSB:0]};
    endfunction

endpackage

// File: rtl/fpu_div_classify.sv
// Combinational operand-class decode and special-result selection for a/b divide.
// Sign is handled by the caller; only magnitudes are examined here.
`timescale 1ns/1ps
module fpu_div_classify
    import fpu_pkg::*;
(
    input  logic [30:0] i_a_mag,
    input  logic [30:0] i_b_mag,
    output logic [2:0]  o_special
);

    logic w_a_exp_max, w_a_exp_zero, w_a_man_nz;
    logic w_b_exp_max, w_b_exp_zero, w_b_man_nz;
    logic w_a_nan, w_a_inf, w_a_zero;
    logic w_b_nan, w_b_inf, w_b_zero;

    assign w_a_exp_max  = &i_a_mag[EXP_MSB:EXP_LSB];
    assign w_a_exp_zero = ~|i_a_mag[EXP_MSB:EXP_LSB];
    assign w_a_man_nz   = |i_a_mag[MAN_MSB:0];
    assign w_b_exp_max  = &i_b_mag[EXP_MSB:EXP_LSB];
    assign w_b_exp_zero = ~|i_b_mag[EXP_MSB:EXP_LSB];
    assign w_b_man_nz   = |i_b_mag[MAN_MSB:0];

    assign w_a_nan  = w_a_exp_max & w_a_man_nz;
    assign w_a_inf  = w_a_exp_max & ~w_a_man_nz;
    assign w_a_zero = w_a_exp_zero & ~w_a_man_nz;
    assign w_b_nan  = w_b_exp_max & w_b_man_nz;
    assign w_b_inf  = w_b_exp_max & ~w_b_man_nz;
    assign w_b_zero = w_b_exp_zero & ~w_b_man_nz;

    // Priority order matters: inf/0 must resolve to inf, not divide-by-zero.
    always_comb begin
        o_special = SPC_NONE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            o_special = SPC_QNAN;
        end else if (w_a_inf) begin
            o_special = SPC_INF;
        end else if (w_b_zero) begin
            o_special = SPC_DZINF;
        end else if (w_a_zero || w_b_inf) begin
            o_special = SPC_ZERO;
        end
    end

endmodule

// File: rtl/fpu_div_ctrl.sv
// Sequencing controller for the single-precision significand divider: accepts one divide,
// resolves special operands locally, otherwise runs the divider and buffers its result.
`timescale 1ns/1ps
module fpu_div_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             div_start,
    output logic [23:0]      sig_A,
    output logic [23:0]      sig_B,
    output logic [8:0]       preNorm_exp,
    output logic             is_exp_underFlow,
    input  logic             div_rdy,
    input  logic [26:0]      div_proNorm_sig,
    input  logic [7:0]       div_proNorm_exp,
    input  logic             OF_from_proNorm,
    input  logic             UF_from_proNorm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_sign,
    output logic [26:0]      rsp_sig,
    output logic [7:0]       rsp_exp,
    output logic             rsp_of,
    output logic             rsp_uf,
    output logic [2:0]       rsp_special,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_busy;
    logic             r_div_start;
    logic [23:0]      r_sig_a;
    logic [23:0]      r_sig_b;
    logic [8:0]       r_pre_exp;
    logic             r_exp_uf;
    logic             r_rsp_valid;
    logic             r_rsp_sign;
    logic [26:0]      r_rsp_sig;
    logic [7:0]       r_rsp_exp;
    logic             r_rsp_of;
    logic             r_rsp_uf;
    logic [2:0]       r_rsp_special;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;

    logic [2:0]       w_special;
    logic             w_accept;
    logic [9:0]       w_diff;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cnt_hit;

    fpu_div_classify u_classify (
        .i_a_mag   (req_a[30:0]),
        .i_b_mag   (req_b[30:0]),
        .o_special (w_special)
    );

    // r_armed holds off acceptance after reset until div_rdy has been seen low once.
    assign req_ready = (r_state == ST_IDLE) & ~flush & r_armed;
    assign w_accept  = req_valid & req_ready;

    assign w_diff = {2'b00, fp_eff_exp(req_a[EXP_MSB:EXP_LSB])}
                  - {2'b00, fp_eff_exp(req_b[EXP_MSB:EXP_LSB])}
                  + 10'(EXP_BIAS);

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_cnt_hit = (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_armed       <= 1'b0;
            r_busy        <= 1'b0;
            r_div_start   <= 1'b0;
            r_sig_a       <= '0;
            r_sig_b       <= '0;
            r_pre_exp     <= '0;
            r_exp_uf      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_sign    <= 1'b0;
            r_rsp_sig     <= '0;
            r_rsp_exp     <= '0;
            r_rsp_of      <= 1'b0;
            r_rsp_uf      <= 1'b0;
            r_rsp_special <= SPC_NONE;
            r_rsp_err     <= 1'b0;
            r_rsp_tag     <= '0;
        end else begin
            r_div_start <= 1'b0;
            if (!div_rdy) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy        <= 1'b1;
                        r_rsp_tag     <= req_tag;
                        r_rsp_sign    <= req_a[SIGN_BIT] ^ req_b[SIGN_BIT];
                        r_rsp_sig     <= '0;
                        r_rsp_exp     <= '0;
                        r_rsp_of      <= 1'b0;
                        r_rsp_uf      <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_special <= w_special;
                        if (w_special != SPC_NONE) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sig_a     <= fp_sig(req_a[30:0]);
                            r_sig_b     <= fp_sig(req_b[30:0]);
                            r_pre_exp   <= w_diff[8:0];
                            r_exp_uf    <= w_diff[9];
                            r_div_start <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush) begin
                        r_cnt <= '0;
                        // A completion landing with the flush leaves nothing to drain.
                        if (div_rdy) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (div_rdy) begin
                        r_rsp_sig   <= div_proNorm_sig;
                        r_rsp_exp   <= div_proNorm_exp;
                        r_rsp_of    <= OF_from_proNorm;
                        r_rsp_uf    <= UF_from_proNorm;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_cnt_hit) begin
                        r_rsp_sign  <= 1'b0;
                        r_rsp_sig   <= '0;
                        r_rsp_exp   <= '0;
                        r_rsp_of    <= 1'b0;
                        r_rsp_uf    <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DRAIN: begin
                    if (div_rdy || w_cnt_hit) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    if (flush || rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_start        = r_div_start;
    assign sig_A            = r_sig_a;
    assign sig_B            = r_sig_b;
    assign preNorm_exp      = r_pre_exp;
    assign is_exp_underFlow = r_exp_uf;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_sign         = r_rsp_sign;
    assign rsp_sig          = r_rsp_sig;
    assign rsp_exp          = r_rsp_exp;
    assign rsp_of           = r_rsp_of;
    assign rsp_uf           = r_rsp_uf;
    assign rsp_special      = r_rsp_special;
    assign rsp_err          = r_rsp_err;
    assign rsp_tag          = r_rsp_tag;
    assign busy             = r_busy;

endmodule
